// File: rtl/alu_salida_reg.sv
// Registered ALU output stage: 16 ops, four status flags, valid/ready output
// handshake and an optional internal carry chain for multi-word arithmetic.
module alu_salida_reg #(
  parameter int WIDTH              = 8,
  parameter bit USE_INTERNAL_CARRY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flagin,
  input  logic [3:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             carry_clr,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             negado,
  output logic             carryo,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] r_out;
  logic             r_ov;
  logic             r_neg;
  logic             r_co;
  logic             r_zero;
  logic             r_valid;
  logic             r_carry;

  logic             w_cin;
  logic             w_accept;
  logic             w_arith;
  logic [WIDTH-1:0] w_opb;
  logic             w_c0;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_co;
  logic             w_ov;

  assign w_cin    = USE_INTERNAL_CARRY ? r_carry : flagin;
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Every add/sub flavour reduces to A + opb + c0 on one adder.
  always_comb begin
    w_arith = 1'b0;
    w_opb   = B;
    w_c0    = 1'b0;
    case (select)
      4'd0:  w_arith = 1'b1;
      4'd1:  begin w_arith = 1'b1; w_opb = ~B; w_c0 = 1'b1; end
      4'd8:  begin w_arith = 1'b1; w_c0 = w_cin; end
      4'd9:  begin w_arith = 1'b1; w_opb = ~B; w_c0 = w_cin; end
      4'd10: begin w_arith = 1'b1; w_opb = '0; w_c0 = 1'b1; end
      4'd11: begin w_arith = 1'b1; w_opb = '1; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, A} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_c0};

  assign w_ov = w_arith && (A[MSB] == w_opb[MSB]) &&
                (w_sum[MSB] != A[MSB]);

  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    w_co  = w_arith ? w_sum[WIDTH] : 1'b0;
    case (select)
      4'd2:  w_res = A & B;
      4'd3:  w_res = A | B;
      4'd4:  w_res = A ^ B;
      4'd5:  w_res = ~A;
      4'd6:  begin w_res = {A[MSB-1:0], w_cin}; w_co = A[MSB]; end
      4'd7:  begin w_res = {w_cin, A[MSB:1]}; w_co = A[0]; end
      4'd12: w_res = A;
      4'd13: w_res = B;
      4'd14: begin w_res = {A[MSB-1:0], A[MSB]}; w_co = A[MSB]; end
      4'd15: begin w_res = {A[0], A[MSB:1]}; w_co = A[0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_ov    <= 1'b0;
      r_neg   <= 1'b0;
      r_co    <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out   <= w_res;
        r_ov    <= w_ov;
        r_neg   <= w_res[MSB];
        r_co    <= w_co;
        r_zero  <= (w_res == '0);
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      // Clear has priority over a coincident load.
      if (carry_clr)
        r_carry <= 1'b0;
      else if (w_accept)
        r_carry <= w_co;
    end
  end

  assign out       = r_out;
  assign overflow  = r_ov;
  assign negado    = r_neg;
  assign carryo    = r_co;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule
